reloj_time_core: RTL and testbench
==================================

// Module: reloj_time_core
// PURPOSE
// - Upstream stage of Selectordisplay. Keeps 24 h wall time (HH:MM) and produces
//   the four 7-seg patterns that Selectordisplay multiplexes onto the shared bus.
// - Two push-buttons set the time: MODE cycles RUN -> SET_HOUR -> SET_MIN -> RUN,
//   and INC advances the selected field. The field being set blinks.
// PARAMETERS
// - CLK_HZ          50_000_000  Clock frequency. Prescaler period for the 1 s tick.
// - DEBOUNCE_CYCLES 500_000     A button level must stay stable this many cycles before it is accepted.
// - BLINK_HALF      12_500_000  Cycles per blink half-period (2 Hz at the default CLK_HZ).
// PORTS
// - Clock     in   1  System clock.
// - Reset     in   1  Asynchronous, active-high reset.
// - btn_mode  in   1  Raw MODE button. Asynchronous, bouncy, active-high.
// - btn_inc   in   1  Raw INC button. Asynchronous, bouncy, active-high.
// - display0  out  7  Minutes, units digit.
// - display1  out  7  Minutes, tens digit.
// - display2  out  7  Hours, units digit.
// - display3  out  7  Hours, tens digit.
// - sec_tick  out  1  One-cycle pulse per elapsed second (RUN only).
// - set_state out  2  00 = RUN, 01 = SET_HOUR, 10 = SET_MIN.
// BEHAVIOUR
// - Clock is one clock domain. Reset is asynchronous and active-high.
// - Segment encoding is active-low (common anode), {a,b,c,d,e,f,g}. Bit 6 = a.
//   Blank = 7'b1111111. Digit 0 = 7'b0000001.
// - Reset values:
//   - Time is 00:00:00 and state is RUN.
//   - Prescaler, debounce and blink counters are 0. Blink phase = on.
//   - display0..3 = 7'b0000001. sec_tick = 0. set_state = 00.
// - Buttons:
//   - 2-flop synchronizer, then a debounce counter, then a rising-edge detector.
//   - Each accepted press yields exactly one 1-cycle event. Releasing the button yields none.
//   - If mode_ev and inc_ev occur in the same cycle, mode_ev wins and inc_ev is discarded.
// - RUN:
//   - Prescaler counts 0..CLK_HZ-1. At CLK_HZ-1 it asserts sec_tick for that cycle and wraps to 0.
//   - On tick, carry chain: sec 59->0 carries into min; min 59->0 carries into hour; hour 23->0.
//     23:59:59 + tick = 00:00:00, all fields updating in the same cycle.
// - SET_HOUR / SET_MIN:
//   - Prescaler and seconds are held at 0. sec_tick = 0.
//   - inc_ev in SET_HOUR: hour+1, wrapping 23->0. Minutes are unaffected.
//   - inc_ev in SET_MIN: min+1, wrapping 59->0. No carry into hours.
// - FSM (transitions on mode_ev only): RUN -> SET_HOUR -> SET_MIN -> RUN.
//   - Leaving SET_MIN clears seconds and the prescaler, so the first tick comes
//     CLK_HZ cycles after the transition.
// - Blink:
//   - A counter toggles the phase every BLINK_HALF cycles.
//   - Counter and phase are forced to phase-on, count 0, on entering any SET state and on every inc_ev.
//   - While phase is off, the selected field's two digits output blank.
//   - In RUN the phase is ignored and all digits are lit.
// - Arithmetic: fields are stored as BCD pairs (tens, units). Unit 9->0 carries into tens.
//   Hour tens is 2 bits, minute tens is 3 bits. No binary-to-BCD divider.
// - Latency: display0..3 are registered, one cycle after the field/blink register changes.
// - A reset asserted mid-operation (any state, any count) returns everything to its
//   reset values immediately. A press still in debounce is lost.
// STRUCTURE
// - Shared include reloj_defs.vh: SEG_BLANK, SEG_DIGIT[0..9] constants, set_state
//   encodings ST_RUN/ST_SET_HOUR/ST_SET_MIN.
// - Sub-module button_conditioner (sync + debounce + edge), instantiated twice.
// - Segment decode is a function or combinational case on the constants. No separate module.
// TESTING (bench params: CLK_HZ=10, DEBOUNCE_CYCLES=3, BLINK_HALF=4)
// - Reset -> display3..0 all 7'b0000001, set_state=00. Ticks every 10 cycles.
//   After 60 ticks display0 = digit 1 (00:01).
// - Preload 23:59:59 via the SET path plus ticks, one more tick -> 00:00.
//   All four digits update in the same cycle. One sec_tick pulse.
// - MODE press -> set_state=01. 5 INC presses -> hour=05. INC x19 more -> wraps to 00 (total 24).
//   Minutes unchanged throughout.
// - SET_MIN, min=59, INC -> min=00 and hour unchanged. MODE -> RUN.
//   First sec_tick exactly 10 cycles after the transition.
// - Bounce: toggle btn_inc each cycle for 8 cycles, then hold 1 for 3 cycles -> exactly one increment.
//   A 2-cycle glitch -> no increment.
// - In SET_HOUR, observe display3/2 blank for 4 cycles then lit for 4 cycles.
//   INC during blank -> lit next cycle. Assert Reset mid-blink -> immediate return to reset values.

Source files
------------

// File: rtl/reloj_time_core_pkg.sv
// Shared definitions for the wall clock core: segment patterns, set-state
// encodings, BCD field types and the small helpers that step them.
package reloj_time_core_pkg;

   // Active-low {a,b,c,d,e,f,g}, bit 6 = a (common anode)
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [9:0][6:0] SEG_DIGIT = {
      7'b0000100,  // 9
      7'b0000000,  // 8
      7'b0001111,  // 7
      7'b0100000,  // 6
      7'b0100100,  // 5
      7'b1001100,  // 4
      7'b0000110,  // 3
      7'b0010010,  // 2
      7'b1001111,  // 1
      7'b0000001   // 0
   };

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_SET_HOUR = 2'b01,
      ST_SET_MIN  = 2'b10
   } set_state_e;

   typedef struct packed {
      logic [2:0] tens;
      logic [3:0] units;
   } bcd60_t;

   typedef struct packed {
      logic [1:0] tens;
      logic [3:0] units;
   } bcd24_t;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      if (d > 4'd9) return SEG_BLANK;
      return SEG_DIGIT[d];
   endfunction

   function automatic logic bcd60_max(input bcd60_t v);
      return (v.tens == 3'd5) && (v.units == 4'd9);
   endfunction

   function automatic bcd60_t bcd60_inc(input bcd60_t v);
      bcd60_t r;
      r = v;
      if (v.units == 4'd9) begin
         r.units = 4'd0;
         r.tens  = (v.tens == 3'd5) ? 3'd0 : v.tens + 3'd1;
      end else begin
         r.units = v.units + 4'd1;
      end
      return r;
   endfunction

   function automatic bcd24_t bcd24_inc(input bcd24_t v);
      bcd24_t r;
      r = v;
      if ((v.tens == 2'd2) && (v.units == 4'd3)) begin
         r = '0;
      end else if (v.units == 4'd9) begin
         r.tens  = v.tens + 2'd1;
         r.units = 4'd0;
      end else begin
         r.units = v.units + 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/reloj_time_core_if.sv
// Button inputs and display/status outputs of the wall clock core.
interface reloj_time_core_if;
   logic       btn_mode;
   logic       btn_inc;
   logic [6:0] display0;
   logic [6:0] display1;
   logic [6:0] display2;
   logic [6:0] display3;
   logic       sec_tick;
   logic [1:0] set_state;

   modport master (
      output btn_mode, btn_inc,
      input  display0, display1, display2, display3, sec_tick, set_state
   );

   modport slave (
      input  btn_mode, btn_inc,
      output display0, display1, display2, display3, sec_tick, set_state
   );
endinterface

// File: rtl/reloj_time_core_button_conditioner.sv
// Raw push-button to single-cycle press event: 2-flop synchronizer,
// stability debounce, then rising-edge detection on the accepted level.
module reloj_time_core_button_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic press_ev
);
   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             stable_q, stable_d;
   logic             ev_q, ev_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The counter only runs while the synchronized level disagrees with the
   // accepted level; any return to agreement restarts the stability window.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      ev_d     = 1'b0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_MAX) begin
            stable_d = sync2_q;
            ev_d     = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
         ev_q     <= 1'b0;
      end else begin
         sync1_q  <= btn_raw;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         ev_q     <= ev_d;
      end
   end

   assign press_ev = ev_q;

endmodule

// File: rtl/reloj_time_core.sv
// 24 h HH:MM wall clock with MODE/INC time setting, blinking set field and
// registered active-low 7-segment outputs for the downstream display mux.
module reloj_time_core
   import reloj_time_core_pkg::*;
#(
   parameter int unsigned CLK_HZ          = 50_000_000,
   parameter int unsigned DEBOUNCE_CYCLES = 500_000,
   parameter int unsigned BLINK_HALF      = 12_500_000
) (
   input logic              clk,
   input logic              rst,
   reloj_time_core_if.slave bus
);
   localparam int unsigned PRESC_W = $clog2(CLK_HZ + 1);
   localparam int unsigned BLINK_W = $clog2(BLINK_HALF + 1);
   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);
   localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_HALF - 1);
   localparam logic [6:0] SEG_ZERO = SEG_DIGIT[0];

   logic mode_ev, inc_ev, inc_ok, tick;
   logic blank_hr, blank_min;

   set_state_e         state_q, state_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   bcd60_t             sec_q, sec_d, min_q, min_d;
   bcd24_t             hr_q, hr_d;
   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic               blink_on_q, blink_on_d;
   logic [6:0]         disp0_q, disp0_d, disp1_q, disp1_d;
   logic [6:0]         disp2_q, disp2_d, disp3_q, disp3_d;

   reloj_time_core_button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_mode (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (bus.btn_mode),
      .press_ev (mode_ev)
   );

   reloj_time_core_button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_inc (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (bus.btn_inc),
      .press_ev (inc_ev)
   );

   // MODE has priority: a simultaneous INC is dropped.
   assign inc_ok = inc_ev & ~mode_ev;

   always_comb begin
      state_d     = state_q;
      presc_d     = presc_q;
      sec_d       = sec_q;
      min_d       = min_q;
      hr_d        = hr_q;
      blink_cnt_d = blink_cnt_q;
      blink_on_d  = blink_on_q;
      tick        = 1'b0;

      unique case (state_q)
         ST_RUN: begin
            if (presc_q == PRESC_MAX) begin
               tick    = 1'b1;
               presc_d = '0;
               sec_d   = bcd60_inc(sec_q);
               if (bcd60_max(sec_q)) begin
                  min_d = bcd60_inc(min_q);
                  if (bcd60_max(min_q)) hr_d = bcd24_inc(hr_q);
               end
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         ST_SET_HOUR: if (inc_ok) hr_d = bcd24_inc(hr_q);
         ST_SET_MIN:  if (inc_ok) min_d = bcd60_inc(min_q);
         default: ;
      endcase

      if (mode_ev) begin
         unique case (state_q)
            ST_RUN:      state_d = ST_SET_HOUR;
            ST_SET_HOUR: state_d = ST_SET_MIN;
            default:     state_d = ST_RUN;
         endcase
      end

      // Seconds and prescaler sit at zero whenever the clock is not running,
      // so returning to RUN restarts a full second.
      if (state_d != ST_RUN) begin
         presc_d = '0;
         sec_d   = '0;
      end

      if ((state_d == ST_RUN) || (state_d != state_q) || inc_ok) begin
         blink_cnt_d = '0;
         blink_on_d  = 1'b1;
      end else if (blink_cnt_q == BLINK_MAX) begin
         blink_cnt_d = '0;
         blink_on_d  = ~blink_on_q;
      end else begin
         blink_cnt_d = blink_cnt_q + 1'b1;
      end
   end

   always_comb begin
      blank_hr  = (state_q == ST_SET_HOUR) && !blink_on_q;
      blank_min = (state_q == ST_SET_MIN) && !blink_on_q;
      disp0_d   = blank_min ? SEG_BLANK : seg_decode(min_q.units);
      disp1_d   = blank_min ? SEG_BLANK : seg_decode({1'b0, min_q.tens});
      disp2_d   = blank_hr  ? SEG_BLANK : seg_decode(hr_q.units);
      disp3_d   = blank_hr  ? SEG_BLANK : seg_decode({2'b00, hr_q.tens});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_RUN;
         presc_q     <= '0;
         sec_q       <= '0;
         min_q       <= '0;
         hr_q        <= '0;
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
         disp0_q     <= SEG_ZERO;
         disp1_q     <= SEG_ZERO;
         disp2_q     <= SEG_ZERO;
         disp3_q     <= SEG_ZERO;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         sec_q       <= sec_d;
         min_q       <= min_d;
         hr_q        <= hr_d;
         blink_cnt_q <= blink_cnt_d;
         blink_on_q  <= blink_on_d;
         disp0_q     <= disp0_d;
         disp1_q     <= disp1_d;
         disp2_q     <= disp2_d;
         disp3_q     <= disp3_d;
      end
   end

   assign bus.display0  = disp0_q;
   assign bus.display1  = disp1_q;
   assign bus.display2  = disp2_q;
   assign bus.display3  = disp3_q;
   assign bus.sec_tick  = tick;
   assign bus.set_state = state_q;

endmodule

// File: tb/tb_reloj_time_core.sv
// Directed bench for reloj_time_core with small prescaler/debounce/blink
// periods; expected segment patterns are tabulated locally.
module tb_reloj_time_core;
   localparam int unsigned CLK_HZ          = 10;
   localparam int unsigned DEBOUNCE_CYCLES = 3;
   localparam int unsigned BLINK_HALF      = 4;
   localparam logic [6:0]  BLANK           = 7'b1111111;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   reloj_time_core_if bus();

   reloj_time_core #(
      .CLK_HZ          (CLK_HZ),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .BLINK_HALF      (BLINK_HALF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] seg(input int n);
      case (n)
         0: return 7'b0000001;
         1: return 7'b1001111;
         2: return 7'b0010010;
         3: return 7'b0000110;
         4: return 7'b1001100;
         5: return 7'b0100100;
         6: return 7'b0100000;
         7: return 7'b0001111;
         8: return 7'b0000000;
         9: return 7'b0000100;
         default: return BLANK;
      endcase
   endfunction

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_time(input string tag, input int h1, input int h0, input int m1, input int m0);
      check({tag, "_d3"}, {25'd0, bus.display3}, {25'd0, seg(h1)});
      check({tag, "_d2"}, {25'd0, bus.display2}, {25'd0, seg(h0)});
      check({tag, "_d1"}, {25'd0, bus.display1}, {25'd0, seg(m1)});
      check({tag, "_d0"}, {25'd0, bus.display0}, {25'd0, seg(m0)});
   endtask

   task automatic press(input bit is_mode);
      if (is_mode) bus.btn_mode = 1'b1;
      else         bus.btn_inc  = 1'b1;
      step(6);
      bus.btn_mode = 1'b0;
      bus.btn_inc  = 1'b0;
      step(6);
   endtask

   task automatic press_inc(input int n);
      repeat (n) press(1'b0);
   endtask

   task automatic wait_lit(input bit hour_field);
      int k;
      k = 0;
      while (((hour_field ? bus.display2 : bus.display0) === BLANK) && (k < 12)) begin
         step();
         k++;
      end
      check("lit_wait", {31'd0, k < 12}, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, cyc, ticks, t1, t2, pulses;
      checks       = 0;
      errors       = 0;
      rst          = 1'b1;
      bus.btn_mode = 1'b0;
      bus.btn_inc  = 1'b0;
      step(3);
      check_time("reset", 0, 0, 0, 0);
      check("reset_state", {30'd0, bus.set_state}, 32'd0);
      check("reset_tick", {31'd0, bus.sec_tick}, 32'd0);
      rst = 1'b0;

      // 60 ticks, 10 cycles apart, advance to 00:01
      ticks = 0; t1 = 0; t2 = 0; k = 0;
      while ((ticks < 60) && (k < 700)) begin
         step();
         k++;
         if (bus.sec_tick === 1'b1) begin
            ticks++;
            if (ticks == 1) t1 = k;
            if (ticks == 2) t2 = k;
         end
      end
      check("tick_count", ticks, 60);
      check("tick_period", t2 - t1, 10);
      step(2);
      check_time("one_minute", 0, 0, 0, 1);

      // SET_HOUR: 5 increments, 19 more wraps to 00, then preload 23
      press(1'b1);
      check("state_set_hour", {30'd0, bus.set_state}, 32'd1);
      press_inc(5);
      wait_lit(1'b1);
      check_time("hour05", 0, 5, 0, 1);
      press_inc(19);
      wait_lit(1'b1);
      check_time("hour_wrap", 0, 0, 0, 1);
      press_inc(23);
      wait_lit(1'b1);
      check_time("hour23", 2, 3, 0, 1);

      // SET_MIN: 59, wrap to 00 without touching hours, back to 59
      press(1'b1);
      check("state_set_min", {30'd0, bus.set_state}, 32'd2);
      press_inc(58);
      wait_lit(1'b0);
      check_time("min59", 2, 3, 5, 9);
      press_inc(1);
      wait_lit(1'b0);
      check_time("min_wrap", 2, 3, 0, 0);
      press_inc(59);
      wait_lit(1'b0);
      check_time("min59b", 2, 3, 5, 9);

      // Back to RUN: first tick in the 10th RUN cycle
      bus.btn_mode = 1'b1;
      k = 0;
      while ((bus.set_state !== 2'b00) && (k < 20)) begin
         step();
         k++;
      end
      check("run_entry", {31'd0, k < 20}, 32'd1);
      bus.btn_mode = 1'b0;
      cyc = 1;
      while ((bus.sec_tick !== 1'b1) && (cyc < 30)) begin
         step();
         cyc++;
      end
      check("first_tick_cycle", cyc, 10);

      // Run up to 23:59:59, then the rollover tick
      ticks = 1; k = 0;
      while ((ticks < 60) && (k < 700)) begin
         step();
         k++;
         if (bus.sec_tick === 1'b1) ticks++;
      end
      check("tick_to_59", ticks, 60);
      check_time("pre_roll", 2, 3, 5, 9);
      pulses = 1;
      step();
      pulses += int'(bus.sec_tick);
      check_time("roll_hold", 2, 3, 5, 9);
      step();
      pulses += int'(bus.sec_tick);
      check_time("rollover", 0, 0, 0, 0);
      repeat (7) begin
         step();
         pulses += int'(bus.sec_tick);
      end
      check("roll_pulses", pulses, 1);

      // Bounce: one increment from 8 toggles + 3 stable cycles; glitch ignored
      press(1'b1);
      check("state_set_hour2", {30'd0, bus.set_state}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         bus.btn_inc = (i % 2 == 0);
         step();
      end
      bus.btn_inc = 1'b1;
      step(3);
      bus.btn_inc = 1'b0;
      step(15);
      wait_lit(1'b1);
      check_time("bounce_once", 0, 1, 0, 0);
      bus.btn_inc = 1'b1;
      step(2);
      bus.btn_inc = 1'b0;
      step(15);
      wait_lit(1'b1);
      check_time("glitch_none", 0, 1, 0, 0);

      // Blink: 4 blank, 4 lit; INC pressed so its event lands in the next blank
      k = 0;
      while ((bus.display2 === BLANK) && (k < 12)) begin
         step();
         k++;
      end
      while ((bus.display2 !== BLANK) && (k < 24)) begin
         step();
         k++;
      end
      check("blink_sync", {31'd0, k < 24}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step();
         check("blink_off_d2", {25'd0, bus.display2}, {25'd0, BLANK});
         check("blink_off_d3", {25'd0, bus.display3}, {25'd0, BLANK});
      end
      bus.btn_inc = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("blink_on_d2", {25'd0, bus.display2}, {25'd0, seg(1)});
         check("blink_on_d3", {25'd0, bus.display3}, {25'd0, seg(0)});
      end
      step();
      check("blank_before_inc_a", {25'd0, bus.display2}, {25'd0, BLANK});
      step();
      check("blank_before_inc_b", {25'd0, bus.display2}, {25'd0, BLANK});
      step();
      check("inc_relights_d2", {25'd0, bus.display2}, {25'd0, seg(2)});
      check("inc_relights_d3", {25'd0, bus.display3}, {25'd0, seg(0)});
      bus.btn_inc = 1'b0;

      // Asynchronous reset while the hour field is blanked
      k = 0;
      while ((bus.display2 !== BLANK) && (k < 12)) begin
         step();
         k++;
      end
      check("blank_before_rst", {25'd0, bus.display2}, {25'd0, BLANK});
      #2;
      rst = 1'b1;
      #1;
      check_time("async_rst", 0, 0, 0, 0);
      check("async_rst_state", {30'd0, bus.set_state}, 32'd0);
      check("async_rst_tick", {31'd0, bus.sec_tick}, 32'd0);
      step(2);
      rst = 1'b0;
      step();
      check_time("post_rst", 0, 0, 0, 0);
      check("post_rst_state", {30'd0, bus.set_state}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
